// File: rtl/erc_seq_div16_8.sv
// Radix-2 restoring divider: 2N-bit dividend / N-bit divisor -> N-bit quotient and remainder, one bit per cycle.
// Latency N cycles (error results 1 cycle); result is held in DONE until out_ready, no new operands meanwhile.
module erc_seq_div16_8 #(
  parameter int N = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [2*N-1:0] dat_in_a,
  input  logic [N-1:0]   dat_in_b,
  input  logic           in_valid,
  output logic           in_ready,
  output logic [N-1:0]   dat_q,
  output logic [N-1:0]   dat_r,
  output logic           err,
  output logic           out_valid,
  input  logic           out_ready,
  output logic           busy
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state, state_nxt;
  logic [N-1:0]  rem;
  logic [N-1:0]  shl;
  logic [N-1:0]  quo;
  logic [N-1:0]  dvs;
  logic [CW-1:0] cnt;
  logic          err_q;
  logic          err_hold;
  logic          div_err;
  logic [N:0]    trial;
  logic          fits;

  assign div_err = (dat_in_b == '0) || (dat_in_a[2*N-1:N] >= dat_in_b);
  assign trial   = {rem, shl[N-1]};
  assign fits    = trial >= {1'b0, dvs};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid) state_nxt = div_err ? DONE : CALC;
      CALC:    if (cnt == '0) state_nxt = DONE;
      DONE:    if (out_valid && out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Error results spend one settle cycle in DONE before being presented.
  always_comb begin
    in_ready  = (state == IDLE);
    busy      = (state == CALC);
    out_valid = (state == DONE) && !err_hold;
  end

  // The partial remainder stays below the divisor, so N bits hold it; only the trial needs N+1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rem      <= '0;
      shl      <= '0;
      quo      <= '0;
      dvs      <= '0;
      cnt      <= '0;
      err_q    <= 1'b0;
      err_hold <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            dvs <= dat_in_b;
            if (div_err) begin
              quo      <= '1;
              rem      <= '0;
              cnt      <= '0;
              err_q    <= 1'b1;
              err_hold <= 1'b1;
            end else begin
              rem   <= dat_in_a[2*N-1:N];
              shl   <= dat_in_a[N-1:0];
              quo   <= '0;
              cnt   <= CW'(N - 1);
              err_q <= 1'b0;
            end
          end
        end
        CALC: begin
          rem <= fits ? N'(trial - {1'b0, dvs}) : trial[N-1:0];
          quo <= {quo[N-2:0], fits};
          shl <= {shl[N-2:0], 1'b0};
          if (cnt != '0) cnt <= cnt - 1'b1;
        end
        DONE: err_hold <= 1'b0;
        default: ;
      endcase
    end
  end

  assign dat_q = quo;
  assign dat_r = rem;
  assign err   = err_q;

endmodule

// File: doc/erc_seq_div16_8.md
# erc_seq_div16_8

Sequential radix-2 restoring divider: 2N-bit dividend by N-bit divisor, N-bit quotient and N-bit remainder, one quotient bit per clock. It is the inverse companion to the 8x8 ERC approximate multiplier array. It serves operand normalisation and error-metric post-processing, where a multiplier product is divided back down. It uses exact arithmetic and valid/ready handshakes on both sides, so it can sit between streaming stages of the multiplier test and characterisation datapath.

## Interface
- N, default 8: divisor, quotient and remainder width; dividend is 2N bits; legal range 4..16.
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous and active-high.
- dat_in_a  in  2N  dividend; sampled only on input handshake.
- dat_in_b  in  N  divisor; sampled only on input handshake.
- in_valid  in  1  upstream offers an operand pair.
- in_ready  out  1  block can accept; high only in IDLE.
- dat_q  out  N  quotient; stable while out_valid=1.
- dat_r  out  N  remainder; stable while out_valid=1.
- err  out  1  divide-by-zero or quotient overflow for the current result.
- out_valid  out  1  result available.
- out_ready  in  1  downstream accepts result.
- busy  out  1  high in CALC.

## Operation
- States: IDLE, CALC, DONE; 2-bit state register; iteration counter of ceil(log2 N) bits.
- IDLE:
  - in_ready=1.
  - On in_valid=1, latch divisor and check for an error.
  - Error condition: dat_in_b==0 or dat_in_a[2N-1:N] >= dat_in_b (the quotient does not fit in N bits).
  - Error: load dat_q=all-ones, dat_r=0, err=1, go to DONE.
  - Otherwise: partial remainder R (N+1 bits) = {0, dat_in_a[2N-1:N]}, shift register L = dat_in_a[N-1:0], quotient Q=0, counter=N-1, err=0, go to CALC.
- CALC, per cycle:
  - T = {R[N-1:0], L[N-1]}.
  - If T >= divisor: R=T-divisor and shift 1 into Q LSB. Otherwise R=T and shift 0 into Q LSB.
  - L shifts left by 1.
  - When counter==0, go to DONE after this iteration's update; otherwise decrement counter.
- R stays < divisor throughout, so N+1 bits never overflow.
- DONE:
  - out_valid=1, dat_q=Q, dat_r=R[N-1:0].
  - Hold all outputs until out_ready=1, then return to IDLE.
- Invariant for err=0: dat_q*dat_in_b + dat_r == dat_in_a, and dat_r < dat_in_b.
- in_valid is ignored outside IDLE, with no buffering and no drop flag. Upstream must hold in_valid until in_ready.
- out_ready is ignored outside DONE.

## Timing
- Reset values (async, immediate): state=IDLE, in_ready=1, out_valid=0, busy=0, err=0, dat_q=0, dat_r=0, counter=0.
- Acceptance edge A is the edge where in_valid and in_ready are both 1.
- Normal latency: out_valid goes high after edge A+N; N cycles of CALC (8 for default).
- Error latency: out_valid goes high after edge A+1; no CALC cycles.
- Result release:
  - The edge with out_valid and out_ready both 1 returns to IDLE; in_ready=1 in the following cycle.
  - Minimum initiation interval is N+2 cycles (normal) and 3 cycles (error).
- out_ready held at 1 before DONE: the result is consumed on the first DONE edge. out_valid is high for exactly one cycle.
- Backpressure: DONE persists indefinitely and outputs do not change.
- Reset asserted mid-CALC or in DONE:
  - Immediate return to reset values; the in-flight result is lost.
  - The first acceptance after deassertion is processed normally.
- dat_q and dat_r show intermediate values during CALC; they are meaningful only while out_valid=1.

## Test plan
- 0x3039 / 0x7B, out_ready=1: out_valid after 8 cycles, dat_q=0x64, dat_r=0x2D, err=0; busy high exactly 8 cycles.
- 0xFEFF / 0xFF (largest legal quotient): dat_q=0xFF, dat_r=0xFE, err=0. Then 0x0000 / 0x01: dat_q=0x00, dat_r=0x00.
- Error cases, each with out_valid 1 cycle after acceptance, dat_q=0xFF, dat_r=0x00, err=1:
  - 0x0012 / 0x00 (divide by zero).
  - 0x6400 / 0x64 (overflow).
- Backpressure: hold out_ready=0 for 20 cycles after 0x1234 / 0x56.
  - Outputs stay at dat_q=0x36, dat_r=0x10, out_valid=1, in_ready=0.
  - in_valid pulses during this window are not accepted.
- Reset: assert rst at the 4th CALC cycle of 0xABCD / 0xEF; all outputs go to reset values asynchronously. After release, 0x0100 / 0x10 yields dat_q=0x10, dat_r=0x00.
- Random: 10k random pairs with random out_ready stalls, checked against a reference model and the invariant dat_q*b+dat_r==a for all err=0 results.
